// File: rtl/riscv_pkg.sv
// riscv_pkg: definitions shared by the RV32 pipeline stages.
//   XLEN           architectural register / address width
//   NOP            canonical bubble instruction (addi x0, x0, 0)
//   fetch_state_e  instruction-fetch FSM states
//   align_pc       forces a fetch address onto a 32-bit word boundary
//   next_pc        sequential successor of a word-aligned PC (wraps mod 2^32)
package riscv_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [XLEN-1:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWait,
        StDrain
    } fetch_state_e;

    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
        return pc & {{(XLEN - 2){1'b1}}, 2'b00};
    endfunction

    function automatic logic [XLEN-1:0] next_pc(input logic [XLEN-1:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/fetch_skid.sv
// fetch_skid: one-entry {instr, pc} buffer that parks a fetch response while
// the IF/ID register is held by a decode stall.
//   clk_i, rst_i     clock, asynchronous active-high reset
//   load_i           capture instr_i/pc_i (entry becomes valid)
//   drain_i          entry consumed this cycle (load_i in the same cycle wins)
//   clear_i          discard the entry (flush); overrides load_i and drain_i
//   instr_i, pc_i    incoming response and its fetch address
//   valid_o          entry holds an instruction
//   instr_o, pc_o    buffered instruction and its PC
module fetch_skid
    import riscv_pkg::*;
(
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            load_i,
    input  logic            drain_i,
    input  logic            clear_i,
    input  logic [XLEN-1:0] instr_i,
    input  logic [XLEN-1:0] pc_i,
    output logic            valid_o,
    output logic [XLEN-1:0] instr_o,
    output logic [XLEN-1:0] pc_o
);

    logic            valid_q, valid_d;
    logic [XLEN-1:0] instr_q, instr_d;
    logic [XLEN-1:0] pc_q, pc_d;

    always_comb begin
        valid_d = valid_q;
        instr_d = instr_q;
        pc_d    = pc_q;
        if (clear_i) begin
            valid_d = 1'b0;
            instr_d = NOP;
        end else if (load_i) begin
            // Load and drain together: the old entry leaves, the new one stays.
            valid_d = 1'b1;
            instr_d = instr_i;
            pc_d    = pc_i;
        end else if (drain_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            instr_q <= NOP;
            pc_q    <= '0;
        end else begin
            valid_q <= valid_d;
            instr_q <= instr_d;
            pc_q    <= pc_d;
        end
    end

    assign valid_o = valid_q;
    assign instr_o = instr_q;
    assign pc_o    = pc_q;

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: RV32 instruction-fetch front end. Owns the PC, issues reads to
// instruction memory with at most one request outstanding, and drives the
// IF/ID register. A one-entry skid absorbs responses that land while decode
// stalls; a redirect flushes IF/ID and the skid and discards a wrong-path
// response still in flight.
//   RESET_PC                   first fetch address after reset (word aligned)
//   clk_i, rst_i               clock, asynchronous active-high reset
//   start_i                    leave IDLE and begin fetching
//   imem_req_o, imem_addr_o    read request and its address (the PC)
//   imem_gnt_i                 request accepted this cycle
//   imem_rvalid_i, imem_rdata_i read response (earliest the cycle after gnt)
//   stall_i                    decode cannot accept; IF/ID holds
//   redirect_i, redirect_pc_i  taken branch/jump and its target
//   instr_o, pc_o, valid_o     IF/ID register contents
module fetch_stage
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start_i,
    output logic            imem_req_o,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic            imem_gnt_i,
    input  logic            imem_rvalid_i,
    input  logic [XLEN-1:0] imem_rdata_i,
    input  logic            stall_i,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    output logic [XLEN-1:0] instr_o,
    output logic [XLEN-1:0] pc_o,
    output logic            valid_o
);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] inflight_pc_q, inflight_pc_d;

    logic            ifid_valid_q, ifid_valid_d;
    logic [XLEN-1:0] ifid_instr_q, ifid_instr_d;
    logic [XLEN-1:0] ifid_pc_q, ifid_pc_d;

    logic            skid_valid;
    logic            skid_load, skid_drain, skid_clear;
    logic [XLEN-1:0] skid_instr, skid_pc;

    logic flush;
    logic resp_valid;
    logic ifid_free;
    logic outstanding;
    logic fire;

    // A redirect before the pipeline is started has nothing to flush and does
    // not start fetching; start_i alone leaves IDLE.
    assign flush       = redirect_i && (state_q != StIdle);
    // Only a response in WAIT belongs to the current path; rvalid in DRAIN is
    // wrong-path data and rvalid in IDLE/ISSUE is spurious.
    assign resp_valid  = imem_rvalid_i && (state_q == StWait);
    assign ifid_free   = !ifid_valid_q || !stall_i;
    assign outstanding = (state_q == StWait) || (state_q == StDrain);
    assign fire        = imem_req_o && imem_gnt_i;

    assign imem_addr_o = pc_q;

    // Request generation. In WAIT the next request overlaps the arriving
    // response only when that response is sure to enter IF/ID directly;
    // otherwise it would occupy the skid and a further response could find
    // no room.
    always_comb begin
        imem_req_o = 1'b0;
        unique case (state_q)
            StIdle:  imem_req_o = 1'b0;
            StIssue: imem_req_o = !skid_valid && !redirect_i;
            StWait:  imem_req_o = imem_rvalid_i && !skid_valid && ifid_free && !redirect_i;
            StDrain: imem_req_o = 1'b0;
            default: imem_req_o = 1'b0;
        endcase
    end

    // FSM next state and PC.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        inflight_pc_d = inflight_pc_q;

        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    state_d = StIssue;
                end
            end
            StIssue: begin
                if (fire) begin
                    state_d = StWait;
                end
            end
            StWait: begin
                if (imem_rvalid_i) begin
                    state_d = fire ? StWait : StIssue;
                end
            end
            StDrain: begin
                if (imem_rvalid_i) begin
                    state_d = StIssue;
                end
            end
            default: state_d = StIdle;
        endcase

        if (fire) begin
            inflight_pc_d = pc_q;
            pc_d          = next_pc(pc_q);
        end

        if (flush) begin
            pc_d = align_pc(redirect_pc_i);
            // A response still owed by memory must be swallowed before refetch.
            state_d = (outstanding && !imem_rvalid_i) ? StDrain : StIssue;
        end
    end

    // IF/ID register and skid control. Skid contents are always older than a
    // response arriving in the same cycle, so the skid empties first.
    always_comb begin
        ifid_valid_d = ifid_valid_q;
        ifid_instr_d = ifid_instr_q;
        ifid_pc_d    = ifid_pc_q;
        skid_load    = 1'b0;
        skid_drain   = 1'b0;
        skid_clear   = 1'b0;

        if (flush) begin
            ifid_valid_d = 1'b0;
            ifid_instr_d = NOP;
            skid_clear   = 1'b1;
        end else if (ifid_free) begin
            if (skid_valid) begin
                ifid_valid_d = 1'b1;
                ifid_instr_d = skid_instr;
                ifid_pc_d    = skid_pc;
                skid_drain   = 1'b1;
                skid_load    = resp_valid;
            end else if (resp_valid) begin
                ifid_valid_d = 1'b1;
                ifid_instr_d = imem_rdata_i;
                ifid_pc_d    = inflight_pc_q;
            end else begin
                ifid_valid_d = 1'b0;
                ifid_instr_d = NOP;
            end
        end else if (resp_valid) begin
            // IF/ID held: the issue rule guarantees the skid is empty here.
            skid_load = 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q       <= StIdle;
            pc_q          <= RESET_PC;
            inflight_pc_q <= '0;
            ifid_valid_q  <= 1'b0;
            ifid_instr_q  <= NOP;
            ifid_pc_q     <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            inflight_pc_q <= inflight_pc_d;
            ifid_valid_q  <= ifid_valid_d;
            ifid_instr_q  <= ifid_instr_d;
            ifid_pc_q     <= ifid_pc_d;
        end
    end

    fetch_skid u_skid (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .load_i  (skid_load),
        .drain_i (skid_drain),
        .clear_i (skid_clear),
        .instr_i (imem_rdata_i),
        .pc_i    (inflight_pc_q),
        .valid_o (skid_valid),
        .instr_o (skid_instr),
        .pc_o    (skid_pc)
    );

    assign instr_o = ifid_instr_q;
    assign pc_o    = ifid_pc_q;
    assign valid_o = ifid_valid_q;

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;
    import riscv_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start;
    logic        imem_req, imem_gnt, imem_rvalid;
    logic [31:0] imem_addr, imem_rdata;
    logic        stall, redirect;
    logic [31:0] redirect_pc;
    logic [31:0] instr, pc_out;
    logic        valid;
    logic        gnt_en;

    // Second instance exercising a non-zero RESET_PC and address wrap.
    logic        rst_hi = 1'b0;
    logic        start_hi;
    logic        req_hi, rvalid_hi, valid_hi;
    logic [31:0] addr_hi, rdata_hi, instr_hi, pc_hi;

    int tests = 0;
    int fails = 0;

    // Memory model: one pending read, returned after a random latency, data = address.
    bit          mem_pend;
    logic [31:0] mem_addr;
    int          mem_cnt;
    int          lat_min, lat_max, gnt_pct;

    // Program-order reference: next address memory should see, next PC decode should take.
    logic [31:0] exp_fetch, exp_pc;
    int          consumed;

    // Pre-edge samples of the last cycle.
    logic        s_req, s_acc, s_valid;
    logic [31:0] s_addr, s_pc, s_instr;

    always #5 clk = ~clk;

    assign imem_gnt = imem_req & gnt_en;

    fetch_stage dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .start_i       (start),
        .imem_req_o    (imem_req),
        .imem_addr_o   (imem_addr),
        .imem_gnt_i    (imem_gnt),
        .imem_rvalid_i (imem_rvalid),
        .imem_rdata_i  (imem_rdata),
        .stall_i       (stall),
        .redirect_i    (redirect),
        .redirect_pc_i (redirect_pc),
        .instr_o       (instr),
        .pc_o          (pc_out),
        .valid_o       (valid)
    );

    fetch_stage #(.RESET_PC(32'hFFFF_FFF8)) dut_hi (
        .clk_i         (clk),
        .rst_i         (rst_hi),
        .start_i       (start_hi),
        .imem_req_o    (req_hi),
        .imem_addr_o   (addr_hi),
        .imem_gnt_i    (req_hi),
        .imem_rvalid_i (rvalid_hi),
        .imem_rdata_i  (rdata_hi),
        .stall_i       (1'b0),
        .redirect_i    (1'b0),
        .redirect_pc_i (32'h0),
        .instr_o       (instr_hi),
        .pc_o          (pc_hi),
        .valid_o       (valid_hi)
    );

    always @(posedge clk or posedge rst_hi) begin
        if (rst_hi) begin
            rvalid_hi <= 1'b0;
            rdata_hi  <= 32'h0;
        end else begin
            rvalid_hi <= req_hi;
            rdata_hi  <= addr_hi;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock cycle of the main DUT, entered and left at a falling edge.
    task automatic cycle(input logic st, input logic rd, input logic [31:0] rpc);
        stall       = st;
        redirect    = rd;
        redirect_pc = rpc;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        if (mem_pend) begin
            mem_cnt--;
            if (mem_cnt == 0) begin
                imem_rvalid = 1'b1;
                imem_rdata  = mem_addr;
            end
        end
        gnt_en = ($urandom_range(99) < gnt_pct);
        #1;
        s_req   = imem_req;
        s_addr  = imem_addr;
        s_acc   = imem_req && gnt_en;
        s_valid = valid;
        s_pc    = pc_out;
        s_instr = instr;
        if (mem_pend && !imem_rvalid) check("req_while_busy", 32'(s_req), 32'h0);
        if (rd) check("req_on_redirect", 32'(s_req), 32'h0);
        if (s_acc) check("fetch_addr", s_addr, exp_fetch);
        if (s_valid && !st && !rd) begin
            check("ifid_pc", s_pc, exp_pc);
            check("ifid_instr", s_instr, exp_pc);
            exp_pc = exp_pc + 32'd4;
            consumed++;
        end
        @(posedge clk);
        if (imem_rvalid) mem_pend = 1'b0;
        if (s_acc) begin
            mem_pend  = 1'b1;
            mem_addr  = s_addr;
            mem_cnt   = $urandom_range(lat_max, lat_min);
            exp_fetch = exp_fetch + 32'd4;
        end
        if (rd) begin
            exp_fetch = rpc & 32'hFFFF_FFFC;
            exp_pc    = rpc & 32'hFFFF_FFFC;
        end
        @(negedge clk);
        if (rd) check("valid_after_redirect", 32'(valid), 32'h0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] held;
        logic [31:0] hi_addrs[$];
        logic [31:0] hi_first_pc;
        bit          hi_seen;
        int          n;
        int          c0;

        start = 0; stall = 0; redirect = 0; redirect_pc = 0;
        imem_rvalid = 0; imem_rdata = 0; gnt_en = 0; start_hi = 0;
        mem_pend = 0; mem_addr = 0; mem_cnt = 0;
        lat_min = 1; lat_max = 1; gnt_pct = 100;
        exp_fetch = 32'h0; exp_pc = 32'h0; consumed = 0;
        hi_seen = 0; hi_first_pc = 0;
        #1 rst = 1; rst_hi = 1;

        // Reset values
        repeat (2) @(negedge clk);
        check("rst_req", 32'(imem_req), 32'h0);
        check("rst_valid", 32'(valid), 32'h0);
        check("rst_instr", instr, NOP);
        check("rst_pc_o", pc_out, 32'h0);
        check("rst_addr", imem_addr, 32'h0);

        // Zero-wait streaming from address 0
        rst = 0; start = 1;
        cycle(0, 0, 0); check("idle_no_req", 32'(s_req), 32'h0);
        start = 0;
        cycle(0, 0, 0); check("c1_req", 32'(s_req), 32'h1); check("c1_addr", s_addr, 32'h0);
        cycle(0, 0, 0); check("c2_addr", s_addr, 32'h4); check("c2_valid", 32'(s_valid), 32'h0);
        cycle(0, 0, 0); check("c3_addr", s_addr, 32'h8); check("c3_valid", 32'(s_valid), 32'h1);
        check("c3_pc", s_pc, 32'h0);
        cycle(0, 0, 0); check("c4_pc", s_pc, 32'h4); check("c4_valid", 32'(s_valid), 32'h1);
        cycle(0, 0, 0); check("c5_pc", s_pc, 32'h8); check("c5_valid", 32'(s_valid), 32'h1);

        // Three-cycle stall with a fetch in flight
        cycle(1, 0, 0); held = s_pc; check("stall_a_req", 32'(s_req), 32'h0);
        cycle(1, 0, 0); check("stall_b_req", 32'(s_req), 32'h0); check("stall_b_pc", s_pc, held);
        cycle(1, 0, 0); check("stall_c_req", 32'(s_req), 32'h0); check("stall_c_pc", s_pc, held);
        cycle(0, 0, 0); check("release_pc", s_pc, held); check("release_req", 32'(s_req), 32'h0);
        repeat (4) cycle(0, 0, 0);

        // Redirect while a response is still owed: it must be drained
        lat_min = 3; lat_max = 3;
        n = 0;
        do begin cycle(0, 0, 0); n++; end while (!s_acc && n < 20);
        check("reach_wait", 32'(s_acc), 32'h1);
        cycle(0, 1, 32'h0000_0103);
        n = 0;
        do begin cycle(0, 0, 0); n++; end while (!s_acc && n < 20);
        check("redirect_first_addr", s_addr, 32'h100);
        n = 0;
        do begin cycle(0, 0, 0); n++; end while (!s_valid && n < 20);
        check("redirect_first_pc", s_pc, 32'h100);

        // Redirect together with stall while the skid is full
        lat_min = 1; lat_max = 1;
        repeat (5) cycle(0, 0, 0);
        cycle(1, 0, 0);
        cycle(1, 1, 32'h0000_0200);
        cycle(1, 0, 0); check("refetch_req", 32'(s_req), 32'h1); check("refetch_addr", s_addr, 32'h200);
        cycle(1, 0, 0);
        cycle(1, 0, 0); check("refetch_valid", 32'(s_valid), 32'h1); check("refetch_pc", s_pc, 32'h200);
        repeat (4) cycle(0, 0, 0);

        // Randomized traffic: variable latency, grant, stalls and redirects
        lat_min = 1; lat_max = 3; gnt_pct = 70;
        c0 = consumed;
        for (int i = 0; i < 500; i++) begin
            logic st, rd;
            st = ($urandom_range(99) < 30);
            rd = ($urandom_range(99) < 4);
            cycle(st, rd, $urandom);
        end
        gnt_pct = 100;
        repeat (10) cycle(0, 0, 0);
        check("random_progress", 32'(consumed - c0 >= 30), 32'h1);

        // Non-zero RESET_PC wraps past the top of the address space
        @(negedge clk);
        rst_hi = 0; start_hi = 1;
        @(negedge clk);
        start_hi = 0;
        for (int i = 0; i < 8; i++) begin
            #1;
            if (req_hi) hi_addrs.push_back(addr_hi);
            if (valid_hi && !hi_seen) begin hi_seen = 1; hi_first_pc = pc_hi; end
            @(negedge clk);
        end
        check("hi_grants", 32'(hi_addrs.size() >= 3), 32'h1);
        if (hi_addrs.size() >= 3) begin
            check("hi_addr0", hi_addrs[0], 32'hFFFF_FFF8);
            check("hi_addr1", hi_addrs[1], 32'hFFFF_FFFC);
            check("hi_addr2", hi_addrs[2], 32'h0000_0000);
        end
        check("hi_first_pc", hi_first_pc, 32'hFFFF_FFF8);

        // Asynchronous reset in WAIT; the late response must be ignored
        lat_min = 2; lat_max = 2;
        n = 0;
        do begin cycle(0, 0, 0); n++; end while (!s_acc && n < 20);
        check("rst_reach_wait", 32'(s_acc), 32'h1);
        stall = 0; redirect = 0; imem_rvalid = 0; gnt_en = 0;
        #2 rst = 1;
        #1;
        check("arst_req", 32'(imem_req), 32'h0);
        check("arst_valid", 32'(valid), 32'h0);
        check("arst_instr", instr, NOP);
        check("arst_pc_o", pc_out, 32'h0);
        check("arst_addr", imem_addr, 32'h0);
        mem_pend = 0;
        @(negedge clk);
        rst = 0; imem_rvalid = 1; imem_rdata = 32'hDEAD_BEEF;
        #1 check("late_rvalid_req", 32'(imem_req), 32'h0);
        @(negedge clk);
        imem_rvalid = 0;
        check("late_rvalid_valid", 32'(valid), 32'h0);
        check("late_rvalid_instr", instr, NOP);
        exp_fetch = 32'h0; exp_pc = 32'h0;
        cycle(0, 0, 0); check("post_rst_idle", 32'(s_valid), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
